// File: rtl/priority_encoder_rr_if.sv
// Request/result handshake bundle for the priority encoder.
// Carries the request vector in and the encoded result out.
interface priority_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] enc_out;
  logic [N-1:0] onehot_out;
  logic [W:0]   cnt_out;
  logic         zero_out;
  logic         multi_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req_in,
    output req_valid,
    output out_ready,
    input  req_ready,
    input  enc_out,
    input  onehot_out,
    input  cnt_out,
    input  zero_out,
    input  multi_out,
    input  out_valid
  );

  modport slave (
    input  req_in,
    input  req_valid,
    input  out_ready,
    output req_ready,
    output enc_out,
    output onehot_out,
    output cnt_out,
    output zero_out,
    output multi_out,
    output out_valid
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// N-to-log2(N) priority encoder, fixed or round-robin.
// One-cycle registered result behind a valid/ready handshake.
module priority_encoder_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input logic                 clk,
  input logic                 rst,
  priority_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic [W-1:0] r_enc;
  logic [N-1:0] r_onehot;
  logic [W:0]   r_cnt;
  logic         r_zero;
  logic         r_multi;
  logic         r_valid;
  logic [W-1:0] r_ptr;

  logic         w_ready;
  logic         w_accept;
  logic [W-1:0] w_start;
  logic         w_found;
  logic [W-1:0] w_win;
  logic [N-1:0] w_onehot;
  logic [W:0]   w_cnt;
  logic [W-1:0] w_next_ptr;

  // No skid buffer: accept only when the result slot frees up.
  assign w_ready  = !r_valid || bus.out_ready;
  assign w_accept = bus.req_valid && w_ready;

  // Fixed priority is round-robin pinned to start at bit 0.
  assign w_start = (MODE == 1) ? r_ptr : '0;

  // Search upward from the start index, wrapping at N-1.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(w_start) + k;
      if (j >= N) j = j - N;
      if (!w_found && bus.req_in[j]) begin
        w_found = 1'b1;
        w_win   = W'(j);
      end
    end
  end

  // Population count of the request vector.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt = w_cnt + {{W{1'b0}}, bus.req_in[i]};
    end
  end

  assign w_onehot = w_found
    ? ({{(N-1){1'b0}}, 1'b1} << w_win)
    : '0;

  assign w_next_ptr = (w_win == W'(N-1))
    ? '0
    : w_win + W'(1);

  // Result registers, valid flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc    <= '0;
      r_onehot <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_multi  <= 1'b0;
      r_valid  <= 1'b0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      r_enc    <= w_win;
      r_onehot <= w_onehot;
      r_cnt    <= w_cnt;
      r_zero   <= !w_found;
      r_multi  <= (w_cnt > (W+1)'(1));
      r_valid  <= 1'b1;
      if (MODE == 1 && w_found) begin
        r_ptr <= w_next_ptr;
      end
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.enc_out    = r_enc;
  assign bus.onehot_out = r_onehot;
  assign bus.cnt_out    = r_cnt;
  assign bus.zero_out   = r_zero;
  assign bus.multi_out  = r_multi;
  assign bus.out_valid  = r_valid;
endmodule

// File: doc/priority_encoder_rr.md
Name: priority_encoder_rr

Overview:
Parametrised N-to-log2(N) priority encoder and the successor to the fixed 4:2 encoder. The input request vector is captured through a valid/ready handshake. A registered result is produced one cycle later: index, one-hot grant, popcount, and zero and multi-hot flags. Priority is either fixed LSB-first or round-robin with a rotating pointer. The block sits between request sources and a downstream consumer that may apply backpressure.

Parameters:
N, 8, number of request inputs; must be at least 2. Powers of two and non-powers of two are both supported.
MODE, 0, priority scheme: 0 = fixed, bit 0 highest; 1 = round-robin.
W, $clog2(N), localparam (derived, not overridable), width of the encoded index.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_in  input  N  request vector, sampled on accept
req_valid  input  1  req_in is valid
req_ready  output  1  block can accept req_in this cycle
enc_out  output  W  encoded index of the winning bit
onehot_out  output  N  one-hot grant; all zeros when zero_out=1
cnt_out  output  W+1  number of set bits in the accepted vector
zero_out  output  1  accepted vector was all zeros
multi_out  output  1  accepted vector had more than one bit set
out_valid  output  1  output registers hold a result
out_ready  input  1  consumer accepts the result

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, enc_out=0, onehot_out=0, cnt_out=0, zero_out=0, multi_out=0.
  - Round-robin pointer ptr=0.
  - Reset takes priority over every other event and discards any held result.
- req_ready = !out_valid || out_ready. This is combinational, with no skid buffer.
- Accept: req_valid && req_ready at a clk edge.
  - On the next edge all outputs update and out_valid=1.
  - Latency is 1 cycle.
  - Full throughput: one result per cycle while out_ready=1.
- Hold: if out_valid=1 and out_ready=0, all outputs stay stable and no input is accepted.
- Drain: if out_valid=1, out_ready=1 and there is no accept, out_valid goes to 0. Data outputs keep their last values.
- Simultaneous drain and accept: out_valid stays 1 and the new result replaces the old one on that edge.
- MODE=0: the winner is the lowest-index set bit.
- MODE=1: the winner is the first set bit found searching upward from ptr, wrapping from N-1 to 0.
  - After a non-zero accept, ptr = winner+1, wrapping to 0 when the winner is N-1.
  - ptr is unchanged in MODE=0 and on zero vectors.
- Zero vector: zero_out=1, enc_out=0, onehot_out=0, cnt_out=0, multi_out=0.
- cnt_out is the full popcount; it reaches N when all bits are set (hence W+1 bits).
- multi_out = (cnt_out > 1).
- req_in bits are ignored when no accept occurs. X on req_in while req_valid=0 must not propagate to the outputs.
- There is no internal state other than the output registers and ptr.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release -> out_valid=0, enc_out=0, cnt_out=0, req_ready=1. Repeat rst=1 while out_valid=1 and out_ready=0 -> out_valid=0 on the next edge.
2. MODE=0, N=8, walking one-hot 00000001 through 10000000 with out_ready=1 -> enc_out 0..7 appears one cycle after each accept, cnt_out=1, multi_out=0, onehot_out equals the input.
3. MODE=0, req_in=10100100 -> enc_out=2, onehot_out=00000100, cnt_out=3, multi_out=1. Then req_in=11111111 -> enc_out=0, cnt_out=8.
4. MODE=1, req_in=10000101 accepted 4 times back-to-back -> enc_out sequence 0, 2, 7, 0. Then req_in=00000000 -> zero_out=1, and the following 10000101 gives enc_out=2, confirming ptr was not moved by the zero vector.
5. Backpressure: out_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, outputs frozen, no accept. Raise out_ready -> the held result drains and the new vector is accepted on the same edge, with out_valid continuously 1.
6. Non-power-of-two build: N=5, MODE=1, req_in=10001 repeated -> enc_out 0, 4, 0, confirming wrap at N-1.
